// File: rtl/accelerator_config_pkg.sv
// Shared widths, FSM state encoding and the FIFO word type for the
// burst fetcher.
package accelerator_config_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_DRAIN,
    FS_DONE
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } fetch_word_t;

endpackage

// File: rtl/dram_burst_fetcher_if.sv
// Command, memory and output-stream signals of the burst fetcher.
// master = fetcher side, slave = system/bench side.
interface dram_burst_fetcher_if #(
  parameter int ADDR_WIDTH = accelerator_config_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = accelerator_config_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = accelerator_config_pkg::LEN_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [31:0]           stall_cycles;

  modport master (
    input  start, base_addr, len, mem_dout, out_ready,
    output busy, done, mem_we, mem_addr, mem_din,
           out_valid, out_data, out_last, stall_cycles
  );

  modport slave (
    output start, base_addr, len, mem_dout, out_ready,
    input  busy, done, mem_we, mem_addr, mem_din,
           out_valid, out_data, out_last, stall_cycles
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_word_t entries with an occupancy count;
// the head entry is presented combinationally.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  accelerator_config_pkg::fetch_word_t push_word,
  input  logic                              pop,
  output accelerator_config_pkg::fetch_word_t head_word,
  output logic                              head_valid,
  output logic [$clog2(DEPTH+1)-1:0]        count
);
  import accelerator_config_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_word_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: state flops use non-blocking assignments so all regs update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; emptiness comes from count_q and stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign head_word  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/dram_burst_fetcher.sv
// Burst read engine: issues len sequential reads to a 1-cycle-latency memory
// and streams the words out. Optional stall counter: FETCH_STALL_CNT_EN.
module dram_burst_fetcher #(
  parameter int ADDR_WIDTH = accelerator_config_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = accelerator_config_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = accelerator_config_pkg::LEN_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dram_burst_fetcher_if.master bus
);
  import accelerator_config_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_last_q, rd_last_d;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  fetch_word_t   push_word, head_word;
  logic          head_valid, pop, issue, start_accept;

  assign pop          = head_valid & bus.out_ready;
  assign start_accept = (state_q == FS_IDLE) & bus.start;

  // Reserve a slot for every read still in the memory pipeline.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_pend_q) - (CW+1)'(pop);
  assign issue     = (state_q == FS_FETCH) && (occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    rd_pend_d = issue;
    rd_last_d = issue && (remain_q == LEN_WIDTH'(1));
    unique case (state_q)
      FS_IDLE: if (bus.start) begin
        if (bus.len == '0) begin
          state_d = FS_DONE;
        end else begin
          state_d  = FS_FETCH;
          addr_d   = bus.base_addr;
          remain_d = bus.len;
        end
      end
      FS_FETCH: if (issue) begin
        remain_d = remain_q - 1'b1;
        if (remain_q == LEN_WIDTH'(1)) state_d = FS_DRAIN;
        else                           addr_d  = addr_q + 1'b1;
      end
      FS_DRAIN: if (pop && head_word.last) state_d = FS_DONE;
      FS_DONE:  state_d = FS_IDLE;
      default:  state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FS_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
    end
  end

  // mem_dout belongs to the read issued last cycle.
  assign push_word = '{data: bus.mem_dout, last: rd_last_q};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_q),
    .push_word (push_word),
    .pop       (pop),
    .head_word (head_word),
    .head_valid(head_valid),
    .count     (fifo_count)
  );

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_valid ? head_word.data : {DATA_WIDTH{1'b0}};
  assign bus.out_last  = head_valid & head_word.last;
  assign bus.busy      = (state_q == FS_FETCH) || (state_q == FS_DRAIN);
  assign bus.done      = (state_q == FS_DONE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_din   = {DATA_WIDTH{1'b0}};

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_accept)                                     stall_d = '0;
    else if (head_valid && !bus.out_ready && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dram_burst_fetcher.sv
// Self-checking bench: DUT paired with a 1-cycle-latency memory (mem[i]=i+0x100),
// a transaction-level expected-word queue and directed literal checks.
module tb_dram_burst_fetcher;
  import accelerator_config_pkg::*;

  localparam int AMAX = 1 << ADDR_WIDTH;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_burst_fetcher_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                          .LEN_WIDTH(LEN_WIDTH)) bus ();

  dram_burst_fetcher #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                       .LEN_WIDTH(LEN_WIDTH), .FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DATA_WIDTH-1:0] mem [AMAX];
  initial for (int i = 0; i < AMAX; i++) mem[i] = DATA_WIDTH'(i + 'h100);
  always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] word_at(input int a);
    return DATA_WIDTH'((a % AMAX) + 'h100);
  endfunction

  // Reference model state
  exp_t                  exp_q[$];
  bit                    m_idle, m_busy, m_done;
  bit                    n_idle, n_busy, n_done;
  int                    stall_exp;
  bit                    prev_stall;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  prev_last;

  // Logs for directed checks
  logic [DATA_WIDTH-1:0] hs_log[$];
  int                    hs_cyc[$];
  int                    first_valid_cyc, done_cyc, t_start;

  task automatic clear_logs();
    hs_log.delete();
    hs_cyc.delete();
    first_valid_cyc = -1;
    done_cyc        = -1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_outputs", {bus.out_valid, bus.out_last, bus.busy, bus.done}, 0);
        check("rst_addr_data", {bus.mem_addr, bus.out_data}, 0);
        check("rst_stall", bus.stall_cycles, 0);
        exp_q.delete();
        m_idle = 1; m_busy = 0; m_done = 0;
        stall_exp = 0; prev_stall = 0;
      end else begin
        check("busy", bus.busy, m_busy);
        check("done", bus.done, m_done);
        check("mem_we_din", {bus.mem_we, bus.mem_din}, 0);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cycles", bus.stall_cycles, stall_exp);
`else
        check("stall_cycles_tied", bus.stall_cycles, 0);
`endif
        if (prev_stall)
          check("hold_during_stall", {bus.out_valid, bus.out_last, bus.out_data},
                {1'b1, prev_last, prev_data});
        if (bus.out_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (exp_q.size() == 0) check("spurious_valid", bus.out_data, 64'hdead_0000);
          else check("stream_word", {bus.out_data, bus.out_last}, {exp_q[0].data, exp_q[0].last});
        end

        n_idle = m_idle; n_busy = m_busy; n_done = 0;
        if (m_done) n_idle = 1;
        if (bus.done) done_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
          hs_log.push_back(bus.out_data);
          hs_cyc.push_back(cyc);
          if (exp_q.size() != 0) begin
            if (exp_q[0].last) begin n_done = 1; n_busy = 0; end
            void'(exp_q.pop_front());
          end
        end
        if (m_idle && bus.start) begin
          n_idle = 0;
          stall_exp = 0;
          if (bus.len == '0) n_done = 1;
          else begin
            n_busy = 1;
            for (int i = 0; i < int'(bus.len); i++)
              exp_q.push_back('{data: word_at(int'(bus.base_addr) + i),
                                last: (i == int'(bus.len) - 1)});
          end
        end else if (bus.out_valid && !bus.out_ready) begin
          stall_exp++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        m_idle = n_idle; m_busy = n_busy; m_done = n_done;
      end
    end
  end

  task automatic send(input int base, input int length);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = ADDR_WIDTH'(base);
    bus.len       = LEN_WIDTH'(length);
    t_start       = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // mode: 0 ready high, 1 toggle, 2 random ready + ignored start re-pulses
  task automatic run_until_idle(input int mode);
    bit reached = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (m_idle && exp_q.size() == 0) begin reached = 1; break; end
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ~bus.out_ready;
        default: begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (m_busy && $urandom_range(0, 7) == 0) begin
            bus.start     = 1'b1;
            bus.base_addr = ADDR_WIDTH'($urandom_range(0, AMAX - 1));
            bus.len       = LEN_WIDTH'($urandom_range(1, 9));
          end else begin
            bus.start = 1'b0;
          end
        end
      endcase
    end
    bus.start = 1'b0;
    if (!reached) check("idle_timeout", 1, 0);
  endtask

  initial begin
    logic [ADDR_WIDTH-1:0] addr_before;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.out_ready = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: four words back-to-back
    bus.out_ready = 1'b1;
    clear_logs();
    send('h10, 4);
    run_until_idle(0);
    check("t1_count", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_data", hs_log[i], 32'h110 + i);
    check("t1_latency", first_valid_cyc - t_start, 3);
    check("t1_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    check("t1_done_after_last", done_cyc - hs_cyc[3], 1);
    check("t1_busy_low", bus.busy, 0);

    // 2: toggling backpressure
    clear_logs();
    send('h20, 8);
    run_until_idle(1);
    check("t2_count", hs_log.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_data", hs_log[i], 32'h120 + i);

    // 3: zero-length burst
    bus.out_ready = 1'b1;
    clear_logs();
    addr_before = bus.mem_addr;
    send('h55, 0);
    run_until_idle(0);
    check("t3_done_t1", done_cyc - t_start, 1);
    check("t3_no_valid", first_valid_cyc, -1);
    check("t3_addr_unchanged", bus.mem_addr, addr_before);

    // 4: address wrap
    clear_logs();
    send(AMAX - 2, 3);
    run_until_idle(0);
    check("t4_count", hs_log.size(), 3);
    check("t4_w0", hs_log[0], 32'h100 + AMAX - 2);
    check("t4_w1", hs_log[1], 32'h100 + AMAX - 1);
    check("t4_w2", hs_log[2], 32'h100);

    // 5: start re-pulsed while busy
    clear_logs();
    send('h40, 5);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 'h80; bus.len = 9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    run_until_idle(0);
    check("t5_count", hs_log.size(), 5);
    for (int i = 0; i < 5; i++) check("t5_data", hs_log[i], 32'h140 + i);

    // 6: asynchronous reset mid-burst with the stream stalled
    bus.out_ready = 1'b0;
    send('h60, 6);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_ctrl", {bus.out_valid, bus.out_last, bus.busy, bus.done}, 0);
    check("t6_async_addr", bus.mem_addr, 0);
    check("t6_async_data", bus.out_data, 0);
    check("t6_async_stall", bus.stall_cycles, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    clear_logs();
    send(0, 2);
    run_until_idle(0);
    check("t6_count", hs_log.size(), 2);
    check("t6_w0", hs_log[0], 32'h100);
    check("t6_w1", hs_log[1], 32'h101);

    // Randomized bursts against the reference model
    for (int b = 0; b < 30; b++) begin
      bus.out_ready = $urandom_range(0, 1);
      send($urandom_range(0, AMAX - 1), $urandom_range(0, 12));
      run_until_idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
